// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter with fixed-priority or round-robin policy, burst-aware handover,
// locked-transfer hold and optional SPLIT masking (define AHB_ARB_SPLIT_EN).
module ahb_arbiter_rr #(
  parameter int NUM_MST  = 4,
  parameter int DEF_MST  = 0,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic               HCLK,
  input  logic               HRST,
  input  logic [NUM_MST-1:0] HBUSREQ,
  input  logic [NUM_MST-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  input  logic [1:0]         HRESP,
  input  logic [15:0]        HSPLIT,
  output logic [NUM_MST-1:0] HGRANT,
  output logic [3:0]         HMASTER,
  output logic               HMASTERLOCK,
  output logic               DefaultMst
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCK} state_e;

  state_e               state_q, state_d;
  logic [7:0]           rem_q, rem_d, burst_len;
  logic [3:0]           gnt_q, gnt_d, ptr_q, ptr_d, mst_q, winner;
  logic                 dflt_q, dflt_d, mlock_q, rearb_q, rearb_d;
  logic [NUM_MST-1:0]   eligible, split_mask, rotated;
  logic [2*NUM_MST-1:0] doubled;
  logic                 found, arb_ok, arb_edge, resp_abort, own_lock, lock_req, keep_grant;
  logic                 unused_hsplit;
  int                   rr_sum;

  assign unused_hsplit = ^HSPLIT;

  always_comb begin
    case (HBURST)
      3'b000:         burst_len = 8'd1;
      3'b001:         burst_len = 8'(MAX_HOLD);
      3'b010, 3'b011: burst_len = 8'd4;
      3'b100, 3'b101: burst_len = 8'd8;
      default:        burst_len = 8'd16;
    endcase
  end

  // RETRY and SPLIT both have HRESP[1] set; the first response cycle has HREADY low
  assign resp_abort = !HREADY && HRESP[1];
  assign arb_ok     = (HTRANS == TR_IDLE) ||
                      (HTRANS == TR_NONSEQ && burst_len == 8'd1) ||
                      (HTRANS == TR_SEQ && rem_q == 8'd1);
  assign arb_edge   = HREADY && (arb_ok || rearb_q);

  always_comb begin
    own_lock = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (gnt_q == 4'(i)) own_lock = HLOCK[i];
    end
  end

  assign lock_req = own_lock && !rearb_q;

  // Round-robin: rotate the eligible vector so bit 0 is the master just after the pointer
  always_comb begin
    eligible = HBUSREQ & ~split_mask;
    doubled  = {eligible, eligible};
    rotated  = NUM_MST'(doubled >> ({1'b0, ptr_q} + 5'd1));
    found    = |eligible;
    winner   = 4'(DEF_MST);
    rr_sum   = 0;
    if (RR_MODE != 0) begin
      for (int k = NUM_MST - 1; k >= 0; k--) begin
        if (rotated[k]) begin
          rr_sum = int'(ptr_q) + 1 + k;
          if (rr_sum >= NUM_MST) rr_sum = rr_sum - NUM_MST;
          winner = 4'(rr_sum);
        end
      end
    end else begin
      for (int k = NUM_MST - 1; k >= 0; k--) begin
        if (eligible[k]) winner = 4'(k);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) state_q <= ST_ARB;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (HREADY) begin
      if (arb_edge)                                                  state_d = lock_req ? ST_LOCK : ST_ARB;
      else if (HTRANS == TR_NONSEQ && burst_len != 8'd1 && state_q != ST_LOCK) state_d = ST_BURST;
    end else if (resp_abort) begin
      state_d = ST_ARB;
    end
  end

  always_comb begin
    keep_grant = (state_d == ST_LOCK);
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    dflt_d     = dflt_q;
    if (arb_edge && !keep_grant) begin
      gnt_d  = winner;
      dflt_d = !found;
      if (found) ptr_d = winner;
    end
  end

  always_comb begin
    rem_d   = rem_q;
    rearb_d = rearb_q;
    if (HREADY) begin
      rearb_d = 1'b0;
      case (HTRANS)
        TR_IDLE:   rem_d = 8'd0;
        TR_BUSY:   rem_d = rem_q;
        TR_NONSEQ: rem_d = burst_len - 8'd1;
        default:   rem_d = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
      endcase
    end else if (resp_abort) begin
      rem_d   = 8'd0;
      rearb_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      rem_q   <= 8'd0;
      gnt_q   <= 4'(DEF_MST);
      ptr_q   <= 4'(NUM_MST - 1);
      mst_q   <= 4'(DEF_MST);
      mlock_q <= 1'b0;
      dflt_q  <= 1'b1;
      rearb_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      dflt_q  <= dflt_d;
      rearb_q <= rearb_d;
      if (HREADY) begin
        mst_q   <= gnt_q;
        mlock_q <= lock_req;
      end
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MST-1:0] split_q, split_d;

  // A release from HSPLIT wins over a SPLIT set in the same cycle
  always_comb begin
    split_d = split_q;
    if (!HREADY && HRESP == 2'b11) begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (mst_q == 4'(i)) split_d[i] = 1'b1;
      end
    end
    split_d = split_d & ~HSPLIT[NUM_MST-1:0];
  end

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) split_q <= '0;
    else      split_q <= split_d;
  end

  assign split_mask = split_q;
`else
  assign split_mask = '0;
`endif

  always_comb begin
    HGRANT = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (gnt_q == 4'(i)) HGRANT[i] = 1'b1;
    end
  end

  assign HMASTER     = mst_q;
  assign HMASTERLOCK = mlock_q;
  assign DefaultMst  = dflt_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr: a round-robin instance (MAX_HOLD=4) and a
// fixed-priority instance share the same stimulus; expected values are hand-computed.
module tb_ahb_arbiter_rr;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NSQ    = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] RETRY  = 2'b10;
  localparam logic [1:0] SPLIT  = 2'b11;

`ifdef AHB_ARB_SPLIT_EN
  localparam logic [3:0] SPLIT_GNT  = 4'b0001;
  localparam logic       SPLIT_DFLT = 1'b1;
`else
  localparam logic [3:0] SPLIT_GNT  = 4'b0100;
  localparam logic       SPLIT_DFLT = 1'b0;
`endif

  logic        HCLK, HRST, HREADY;
  logic [3:0]  HBUSREQ, HLOCK;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HBURST;
  logic [15:0] HSPLIT;
  logic [3:0]  rrGrant, rrMaster, fpGrant, fpMaster;
  logic        rrLock, rrDefault, fpLock, fpDefault;

  int numCompared = 0;
  int numMismatch = 0;

  logic [3:0] rrExp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] mstExp [5] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};

  ahb_arbiter_rr #(.NUM_MST(4), .DEF_MST(0), .RR_MODE(1), .MAX_HOLD(4)) dutRr (
    .HCLK(HCLK), .HRST(HRST), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .HSPLIT(HSPLIT),
    .HGRANT(rrGrant), .HMASTER(rrMaster), .HMASTERLOCK(rrLock), .DefaultMst(rrDefault)
  );

  ahb_arbiter_rr #(.NUM_MST(4), .DEF_MST(0), .RR_MODE(0), .MAX_HOLD(16)) dutFp (
    .HCLK(HCLK), .HRST(HRST), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .HSPLIT(HSPLIT),
    .HGRANT(fpGrant), .HMASTER(fpMaster), .HMASTERLOCK(fpLock), .DefaultMst(fpDefault)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                               input logic [2:0] burst, input logic rdy, input logic [1:0] resp,
                               input logic [15:0] split);
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = rdy;
    HRESP   = resp;
    HSPLIT  = split;
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    numCompared++;
    assert (actual === expected) else begin
      numMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic resetDut();
    HRST    = 1'b1;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = IDLE;
    HBURST  = SINGLE;
    HREADY  = 1'b1;
    HRESP   = OKAY;
    HSPLIT  = '0;
    #4;
    HRST = 1'b0;
  endtask

  initial begin
    HRST = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE;
    HREADY = 1'b1; HRESP = OKAY; HSPLIT = '0;
    #7;
    checkOutput("rst_grant", rrGrant, 4'b0001);
    checkOutput("rst_master", rrMaster, 4'd0);
    checkOutput("rst_mlock", rrLock, 1'b0);
    checkOutput("rst_default", rrDefault, 1'b1);
    checkOutput("rst_fp_default", fpDefault, 1'b1);
    #3;
    HRST = 1'b0;

    // Idle bus parks on the default master, then hands over to the first requester
    applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("idle_grant", rrGrant, 4'b0001);
    checkOutput("idle_default", rrDefault, 1'b1);
    applyStimulus(4'b0110, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("req_grant", rrGrant, 4'b0010);
    checkOutput("req_master", rrMaster, 4'd0);
    checkOutput("req_default", rrDefault, 1'b0);
    applyStimulus(4'b0110, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("handover_master", rrMaster, 4'd1);
    checkOutput("handover_grant", rrGrant, 4'b0100);

    // All masters requesting with SINGLE transfers
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, OKAY, 16'h0);
      checkOutput($sformatf("rr_grant%0d", i), rrGrant, rrExp[i]);
      checkOutput($sformatf("rr_master%0d", i), rrMaster, mstExp[i]);
      checkOutput($sformatf("fp_grant%0d", i), fpGrant, 4'b0001);
    end
    checkOutput("fp_master", fpMaster, 4'd0);

    // INCR8 by master 2 while master 1 waits
    resetDut();
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("incr8_setup", rrGrant, 4'b0100);
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("incr8_owner", rrMaster, 4'd2);
    applyStimulus(4'b0110, 4'b0000, NSQ, INCR8, 1'b1, OKAY, 16'h0);
    checkOutput("incr8_b1", rrGrant, 4'b0100);
    for (int b = 2; b <= 7; b++) begin
      applyStimulus(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, OKAY, 16'h0);
      checkOutput($sformatf("incr8_b%0d", b), rrGrant, 4'b0100);
    end
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, OKAY, 16'h0);
    checkOutput("incr8_b8", rrGrant, 4'b0010);

    // INCR4 by master 1 with wait states
    applyStimulus(4'b0110, 4'b0000, NSQ, INCR4, 1'b1, OKAY, 16'h0);
    checkOutput("stall_b1", rrGrant, 4'b0010);
    checkOutput("stall_master", rrMaster, 4'd1);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b0, OKAY, 16'h0);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY, 16'h0);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b0, OKAY, 16'h0);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY, 16'h0);
    checkOutput("stall_b3", rrGrant, 4'b0010);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b0, OKAY, 16'h0);
    checkOutput("stall_last_wait", rrGrant, 4'b0010);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY, 16'h0);
    checkOutput("stall_last", rrGrant, 4'b0100);

    // Undefined-length INCR is cut off after MAX_HOLD=4 beats
    applyStimulus(4'b1100, 4'b0000, NSQ, INCR, 1'b1, OKAY, 16'h0);
    checkOutput("hold_b1", rrGrant, 4'b0100);
    applyStimulus(4'b1100, 4'b0000, SEQ, INCR, 1'b1, OKAY, 16'h0);
    applyStimulus(4'b1100, 4'b0000, SEQ, INCR, 1'b1, OKAY, 16'h0);
    checkOutput("hold_b3", rrGrant, 4'b0100);
    applyStimulus(4'b1100, 4'b0000, SEQ, INCR, 1'b1, OKAY, 16'h0);
    checkOutput("hold_b4", rrGrant, 4'b1000);

    // Master 3 keeps the bus locked across two INCR4 bursts
    for (int burstNum = 0; burstNum < 2; burstNum++) begin
      applyStimulus(4'b1111, 4'b1000, NSQ, INCR4, 1'b1, OKAY, 16'h0);
      checkOutput($sformatf("lock_mlock%0d", burstNum), rrLock, 1'b1);
      for (int b = 0; b < 3; b++) applyStimulus(4'b1111, 4'b1000, SEQ, INCR4, 1'b1, OKAY, 16'h0);
      checkOutput($sformatf("lock_grant%0d", burstNum), rrGrant, 4'b1000);
      checkOutput($sformatf("lock_master%0d", burstNum), rrMaster, 4'd3);
    end
    applyStimulus(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("unlock_grant", rrGrant, 4'b0001);
    checkOutput("unlock_mlock", rrLock, 1'b0);

    // RETRY on master 1 mid-INCR4
    applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("retry_setup", rrGrant, 4'b0010);
    applyStimulus(4'b1010, 4'b0000, NSQ, INCR4, 1'b1, OKAY, 16'h0);
    applyStimulus(4'b1010, 4'b0000, SEQ, INCR4, 1'b1, OKAY, 16'h0);
    applyStimulus(4'b1010, 4'b0000, SEQ, INCR4, 1'b0, RETRY, 16'h0);
    checkOutput("retry_first", rrGrant, 4'b0010);
    applyStimulus(4'b1010, 4'b0000, SEQ, INCR4, 1'b1, RETRY, 16'h0);
    checkOutput("retry_rearb", rrGrant, 4'b1000);
    applyStimulus(4'b1010, 4'b0000, SEQ, INCR4, 1'b1, OKAY, 16'h0);
    checkOutput("retry_rem_clr", rrGrant, 4'b1000);
    applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("retry_eligible", rrGrant, 4'b0010);

    // SPLIT on master 2, later released through HSPLIT
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("split_owner", rrMaster, 4'd2);
    applyStimulus(4'b0100, 4'b0000, NSQ, INCR4, 1'b1, OKAY, 16'h0);
    applyStimulus(4'b0100, 4'b0000, SEQ, INCR4, 1'b0, SPLIT, 16'h0);
    checkOutput("split_first", rrGrant, 4'b0100);
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, SPLIT, 16'h0);
    checkOutput("split_grant", rrGrant, SPLIT_GNT);
    checkOutput("split_default", rrDefault, SPLIT_DFLT);
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("split_masked", rrGrant, SPLIT_GNT);
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0004);
    checkOutput("split_release_edge", rrGrant, SPLIT_GNT);
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("split_regrant", rrGrant, 4'b0100);
    checkOutput("split_regrant_dflt", rrDefault, 1'b0);

    // Reset asserted in the middle of a burst
    applyStimulus(4'b0100, 4'b0000, NSQ, INCR8, 1'b1, OKAY, 16'h0);
    HRST = 1'b1;
    #1;
    checkOutput("midrst_grant", rrGrant, 4'b0001);
    checkOutput("midrst_master", rrMaster, 4'd0);
    checkOutput("midrst_default", rrDefault, 1'b1);
    #3;
    HRST = 1'b0;
    applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 16'h0);
    checkOutput("postrst_grant", rrGrant, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatch);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_rr.md
Name: ahb_arbiter_rr

Overview:
Parametrised AHB bus arbiter for the multi-master AHB fabric. Sits beside the address/data mux and drives HGRANT, HMASTER and HMASTERLOCK.
Generalises the fixed 4-master arbiter in four ways:
- configurable master count;
- selectable fixed-priority or round-robin policy;
- burst-aware handover with a beat counter and a hold limit for undefined-length INCR;
- locked-transfer hold and SPLIT masking.

Parameters:
NUM_MST, 4, number of masters (2..16).
DEF_MST, 0, default master index; granted when nobody requests.
RR_MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin.
MAX_HOLD, 16, beat limit for HBURST=INCR before forced re-arbitration (2..255).

Ports:
HCLK  in  1  bus clock
HRST  in  1  asynchronous reset, active-high
HBUSREQ  in  NUM_MST  per-master bus request
HLOCK  in  NUM_MST  per-master lock request
HTRANS  in  2  muxed transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HBURST  in  3  muxed burst type
HREADY  in  1  muxed slave ready
HRESP  in  2  muxed response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)
HSPLIT  in  16  OR of all slave split-release vectors
HGRANT  out  NUM_MST  one-hot grant
HMASTER  out  4  address-phase owner index
HMASTERLOCK  out  1  current transfer is locked
DefaultMst  out  1  default master granted because no request is pending

Behaviour:
Reset (HRST=1, async):
- HGRANT = 1<<DEF_MST; HMASTER = DEF_MST; HMASTERLOCK = 0; DefaultMst = 1.
- RR pointer = NUM_MST-1, so master 0 wins first.
- Beat counter REM = 0; split mask = 0; FSM = ARB.
- A reset asserted mid-burst aborts immediately to these values.

Burst length len from HBURST: SINGLE 1; INCR MAX_HOLD; WRAP4/INCR4 4; WRAP8/INCR8 8; WRAP16/INCR16 16.

Beat counter, updated only at edges with HREADY=1:
- NONSEQ loads REM = len-1.
- SEQ decrements REM, saturating at 0.
- IDLE clears REM.
- BUSY holds REM.

arb_ok (combinational) = HTRANS==IDLE, or (NONSEQ and len==1), or (SEQ and REM==1).

FSM states:
- ARB: arb_ok is true every cycle.
- BURST: entered on an accepted NONSEQ with len>1; returns to ARB when the last beat is accepted.
- LOCK: entered when the granted owner holds HLOCK at an arbitration edge; leaves on the first arbitration edge where the owner's HLOCK=0.

Grant update:
- At an edge with HREADY=1 and arb_ok, HGRANT is re-evaluated. Grant therefore moves during the last address beat.
- In LOCK, HGRANT stays on the owner regardless of other requests.
- Eligible set = HBUSREQ & ~split_mask.
- RR_MODE=1: search from pointer+1 upward, modulo NUM_MST; the pointer takes the winner index.
- RR_MODE=0: lowest eligible index wins.
- Empty eligible set: grant DEF_MST and DefaultMst=1; otherwise DefaultMst=0.

Handover:
- HMASTER <= index(HGRANT) and HMASTERLOCK <= HLOCK[granted] at every edge with HREADY=1, i.e. one cycle after the grant change.
- HREADY=0 freezes HGRANT, HMASTER, HMASTERLOCK, REM and FSM, except for the response handling below.

Responses (first response cycle has HREADY=0):
- RETRY/SPLIT: on the first cycle, force REM=0 and FSM=ARB. At the next HREADY=1 edge, arbitrate as if arb_ok. The retried owner remains eligible, but the RR pointer has already passed it.
- ERROR: does not force re-arbitration; the burst continues under master control.

Simultaneous events:
- HLOCK with RETRY: the lock is dropped (SPLIT/RETRY overrides LOCK).
- Request deasserted mid-burst: no effect until arb_ok.
- Requests for indices >= NUM_MST: ignored.

Optional Feature:
AHB_ARB_SPLIT_EN
- Defined:
  - A SPLIT response sets split_mask[HMASTER] on its first cycle.
  - At every edge, split_mask bits are cleared where HSPLIT[i]=1; a clear wins over a set in the same cycle.
  - If all requesters are masked, DEF_MST is granted.
- Undefined: split_mask is constant 0, HSPLIT is ignored, and SPLIT is handled exactly as RETRY.

Test Plan:
1. Reset release with HBUSREQ=0 -> HGRANT=0001, HMASTER=0, DefaultMst=1. Then HBUSREQ=0110 with IDLE traffic -> HGRANT=0010 next edge, HMASTER=1 the edge after, DefaultMst=0.
2. RR_MODE=1, HBUSREQ=1111 held, SINGLE transfers -> owners cycle 0,1,2,3,0; RR_MODE=0 with the same stimulus -> master 0 always.
3. Master 2 issues INCR8 with HREADY=1 and master 1 requesting -> HGRANT stays 0100 for 7 beats, switches to 0010 during beat 8; with HREADY=0 stalls inserted, the grant change is delayed accordingly.
4. INCR with MAX_HOLD=4 and master 3 requesting -> grant moves after beat 4 is presented. Separately: owner asserts HLOCK over two bursts with others requesting -> no grant change, HMASTERLOCK=1 until HLOCK drops.
5. RETRY on master 1 during INCR4 -> REM cleared; grant moves to the next RR requester at the HREADY=1 edge.
6. With AHB_ARB_SPLIT_EN, SPLIT on master 2 -> master 2 ungranted while HBUSREQ[2]=1; HSPLIT[2]=1 pulse -> master 2 eligible again. Without the macro, the same stimulus behaves like case 5.
